// File: rtl/gate_sweep_if.sv
// Purpose: bundles the sweep controller's master-facing and gate-facing signals.
// Ports: start/gate_z flow into the controller; gate_x/gate_y, busy, done,
//        pass, err_count and fail_vec flow out of it.
interface gate_sweep_if;
    logic       start;      // sweep request from the test/config master
    logic       gate_x;     // drives gate input x
    logic       gate_y;     // drives gate input y
    logic       gate_z;     // gate output under test
    logic       busy;       // sweep in progress
    logic       done;       // single-cycle end-of-sweep pulse
    logic       pass;       // result of the last completed sweep
    logic [2:0] err_count;  // mismatches in the current/last sweep
    logic [3:0] fail_vec;   // per-vector mismatch flags

    // Controller side.
    modport slave (
        input  start, gate_z,
        output gate_x, gate_y, busy, done, pass, err_count, fail_vec
    );

    // Environment side: the test master plus the gate under test.
    modport master (
        output start, gate_z,
        input  gate_x, gate_y, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Purpose: walks a 2-input gate through {x,y} = 00,01,10,11, waits SETTLE
//          cycles per vector, samples z against EXPECT and reports pass/fail.
// Ports: clk, rst (sync, active-high); sw = gate_sweep_if.slave carrying
//        start, gate x/y/z, busy, done, pass, err_count, fail_vec.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE = 2,        // legal range 1..15
    parameter logic [3:0]  EXPECT = 4'b1000   // EXPECT[{x,y}] = required z
) (
    input  logic          clk,
    input  logic          rst,
    gate_sweep_if.slave   sw
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q,   idx_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       x_q,     x_d;
    logic       y_q,     y_d;
    logic [2:0] err_q,   err_d;
    logic [3:0] fail_q,  fail_d;
    logic       pass_q,  pass_d;
    logic [1:0] idx_nxt;

    assign idx_nxt = idx_q + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE: begin
                // Results of the previous sweep stay visible until a new
                // sweep is accepted; they clear on that same edge.
                if (sw.start) begin
                    state_d = APPLY;
                    idx_d   = 2'd0;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                    err_d   = 3'd0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                cnt_d   = 4'd0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (sw.gate_z != EXPECT[idx_q]) begin
                    err_d         = err_q + 3'd1;
                    fail_d[idx_q] = 1'b1;
                end
                if (idx_q == 2'd3) begin
                    state_d = FINISH;
                end else begin
                    // Next vector goes onto the gate on the edge entering APPLY.
                    idx_d   = idx_nxt;
                    x_d     = idx_nxt[1];
                    y_d     = idx_nxt[0];
                    state_d = APPLY;
                end
            end
            FINISH: begin
                // err_q already counts vector 3 (updated leaving SAMPLE).
                pass_d  = (err_q == 3'd0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sw.gate_x    = x_q;
    assign sw.gate_y    = y_q;
    assign sw.busy      = (state_q != IDLE);
    assign sw.done      = (state_q == FINISH);
    assign sw.pass      = pass_q;
    assign sw.err_count = err_q;
    assign sw.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
module tb_gate_sweep_ctrl;

    localparam logic [3:0] EXP_TT = 4'b1000;   // expected truth table (AND)

    typedef struct {
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_drv = 1'b0;
    logic sel = 1'b0;          // 0: SETTLE=2 instance, 1: SETTLE=1 instance
    int   mode = 0;            // 0: AND gate, 1: z stuck at 0, 2: OR gate
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    gate_sweep_if if0 ();
    gate_sweep_if if1 ();

    function automatic logic z_model(input int m, input logic x, input logic y);
        case (m)
            0:       return x & y;
            1:       return 1'b0;
            default: return x | y;
        endcase
    endfunction

    assign if0.start  = start_drv & ~sel;
    assign if1.start  = start_drv & sel;
    assign if0.gate_z = z_model(mode, if0.gate_x, if0.gate_y);
    assign if1.gate_z = z_model(mode, if1.gate_x, if1.gate_y);

    gate_sweep_ctrl #(.SETTLE(2), .EXPECT(EXP_TT)) u_dut2 (.clk(clk), .rst(rst), .sw(if0));
    gate_sweep_ctrl #(.SETTLE(1), .EXPECT(EXP_TT)) u_dut1 (.clk(clk), .rst(rst), .sw(if1));

    logic       obs_x, obs_y, obs_busy, obs_done, obs_pass;
    logic [2:0] obs_err;
    logic [3:0] obs_fv;
    assign obs_x    = sel ? if1.gate_x    : if0.gate_x;
    assign obs_y    = sel ? if1.gate_y    : if0.gate_y;
    assign obs_busy = sel ? if1.busy      : if0.busy;
    assign obs_done = sel ? if1.done      : if0.done;
    assign obs_pass = sel ? if1.pass      : if0.pass;
    assign obs_err  = sel ? if1.err_count : if0.err_count;
    assign obs_fv   = sel ? if1.fail_vec  : if0.fail_vec;

    // One full sweep: drives start, checks x/y timing every cycle, checks the
    // done cycle and the scoreboarded result. rst_at >= 0 aborts the sweep
    // with a reset after that many edges; rs_a/rs_b re-pulse start mid-sweep.
    task automatic run_sweep(input logic s_sel, input int m, input int rst_at,
                             input int rs_a, input int rs_b);
        int         settle, total, nerr;
        exp_t       e, g;
        logic [1:0] idx;
        logic [1:0] vi;
        sel = s_sel;
        mode = m;
        settle = s_sel ? 1 : 2;
        total = 4 * (settle + 2);
        e.fv = 4'd0;
        nerr = 0;
        for (int i = 0; i < 4; i++) begin
            vi = 2'(i);
            if (z_model(m, vi[1], vi[0]) !== EXP_TT[i]) begin
                e.fv[i] = 1'b1;
                nerr++;
            end
        end
        e.err = 3'(nerr);
        e.pass = (nerr == 0);

        @(negedge clk); start_drv = 1'b1;
        @(posedge clk); #1; start_drv = 1'b0;
        if (rst_at < 0) sb.push_back(e);
        n_cmp++; if (obs_busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b want 1", obs_busy); end
        n_cmp++; if (obs_pass !== 1'b0) begin n_err++; $display("FAIL start_pass_clr: got %b want 0", obs_pass); end
        n_cmp++; if (obs_err !== 3'd0) begin n_err++; $display("FAIL start_err_clr: got %0d want 0", obs_err); end
        n_cmp++; if (obs_fv !== 4'd0) begin n_err++; $display("FAIL start_fv_clr: got %b want 0000", obs_fv); end
        n_cmp++; if ({obs_x, obs_y} !== 2'b00) begin n_err++; $display("FAIL start_xy: got %b want 00", {obs_x, obs_y}); end

        for (int k = 1; k <= total; k++) begin
            @(posedge clk); #1;
            start_drv = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                n_cmp++; if ({obs_x, obs_y, obs_busy, obs_done, obs_pass} !== 5'd0) begin
                    n_err++; $display("FAIL abort_outputs: got x/y/busy/done/pass=%b want 00000", {obs_x, obs_y, obs_busy, obs_done, obs_pass}); end
                n_cmp++; if ({obs_err, obs_fv} !== 7'd0) begin
                    n_err++; $display("FAIL abort_results: got err=%0d fv=%b want 0/0000", obs_err, obs_fv); end
                for (int j = 0; j < total; j++) begin
                    @(posedge clk); #1;
                    n_cmp++; if (obs_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: cycle %0d got 1 want 0", j); end
                end
                return;
            end
            if (k == rs_a || k == rs_b) start_drv = 1'b1;
            if (k < total) begin
                idx = 2'(k / (settle + 2));
                n_cmp++; if ({obs_x, obs_y} !== idx) begin n_err++; $display("FAIL xy_seq: edge %0d got %b want %b", k, {obs_x, obs_y}, idx); end
                n_cmp++; if (obs_done !== 1'b0) begin n_err++; $display("FAIL early_done: edge %0d got 1 want 0", k); end
            end else begin
                n_cmp++; if (obs_done !== 1'b1) begin n_err++; $display("FAIL done_time: edge %0d got %b want 1", k, obs_done); end
                n_cmp++; if (obs_busy !== 1'b1) begin n_err++; $display("FAIL finish_busy: got %b want 1", obs_busy); end
                n_cmp++; if (obs_pass !== 1'b0) begin n_err++; $display("FAIL finish_pass: got %b want 0", obs_pass); end
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL sb_empty: got no entry want one");
                end else begin
                    g = sb.pop_front();
                    if (obs_err !== g.err || obs_fv !== g.fv) begin
                        n_err++; $display("FAIL result: got err=%0d fv=%b want err=%0d fv=%b", obs_err, obs_fv, g.err, g.fv);
                    end
                end
            end
        end

        @(posedge clk); #1;
        n_cmp++; if (obs_pass !== e.pass) begin n_err++; $display("FAIL pass: got %b want %b", obs_pass, e.pass); end
        n_cmp++; if (obs_err !== e.err) begin n_err++; $display("FAIL err_hold: got %0d want %0d", obs_err, e.err); end
        n_cmp++; if (obs_fv !== e.fv) begin n_err++; $display("FAIL fv_hold: got %b want %b", obs_fv, e.fv); end
        for (int j = 0; j < 3; j++) begin
            n_cmp++; if ({obs_busy, obs_done} !== 2'b00) begin
                n_err++; $display("FAIL idle_after: cycle %0d got busy/done=%b want 00", j, {obs_busy, obs_done}); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_drv = 1'b1;   // rst must win over start
        repeat (3) @(posedge clk);
        #1;
        start_drv = 1'b0;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_cmp++; if ({obs_x, obs_y, obs_busy, obs_done, obs_pass} !== 5'd0) begin
                n_err++; $display("FAIL reset_outputs: sel %0d got %b want 00000", s, {obs_x, obs_y, obs_busy, obs_done, obs_pass}); end
            n_cmp++; if ({obs_err, obs_fv} !== 7'd0) begin
                n_err++; $display("FAIL reset_results: sel %0d got err=%0d fv=%b want 0/0000", s, obs_err, obs_fv); end
        end
        sel = 1'b0;
    endtask

    task automatic test_and_pass();     run_sweep(1'b0, 0, -1, -1, -1); endtask
    task automatic test_stuck0();       run_sweep(1'b0, 1, -1, -1, -1); endtask
    task automatic test_or_gate();      run_sweep(1'b0, 2, -1, -1, -1); endtask

    task automatic test_abort();
        run_sweep(1'b0, 0, 7, -1, -1);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL abort_sb: got %0d entries want 0", sb.size()); end
        run_sweep(1'b0, 0, -1, -1, -1);
    endtask

    task automatic test_restart_ignored(); run_sweep(1'b0, 0, -1, 3, 10); endtask

    task automatic test_back_to_back();
        run_sweep(1'b0, 0, -1, -1, -1);
        run_sweep(1'b0, 1, -1, -1, -1);
    endtask

    task automatic test_settle1();
        run_sweep(1'b1, 0, -1, -1, -1);
        run_sweep(1'b1, 2, -1, -1, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_and_pass();
        test_stuck0();
        test_or_gate();
        test_abort();
        test_restart_ignored();
        test_back_to_back();
        test_settle1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Self-test sequencer for a 2-input logic gate such as and_gate. It drives the gate's x/y inputs through all four combinations and waits a programmable settle time. It then samples z, compares it against an expected truth table, and reports pass/fail plus per-vector failure flags. It sits between a top-level test/config master (start/done) and the gate under test.

Parameters:
SETTLE, 2, cycles waited after the gate inputs are applied and before z is sampled; legal range 1..15
EXPECT, 4'b1000, expected truth table; EXPECT[{x,y}] is the required z (default = AND)

Ports:
clk  in  1  clock, rising-edge active
rst  in  1  reset, synchronous, active-high
start  in  1  request a sweep; sampled only in IDLE
gate_x  out  1  drives gate input x
gate_y  out  1  drives gate input y
gate_z  in  1  gate output under test
busy  out  1  high from the cycle after start is accepted through the FINISH cycle
done  out  1  single-cycle pulse at the end of a sweep
pass  out  1  result of the last completed sweep; held until the next start or rst
err_count  out  3  mismatches in the current or last sweep (0..4)
fail_vec  out  4  bit i set if vector i ({x,y}=i) mismatched

Behaviour:
- Reset: rst high at a clock edge -> state IDLE; gate_x, gate_y, busy, done, pass = 0; err_count = 0; fail_vec = 0; internal idx = 0; cnt = 0. Reset aborts any sweep in progress, and no done is produced for it.
- States: IDLE, APPLY, WAIT, SAMPLE, FINISH. Moore outputs: done = (state==FINISH); busy = (state!=IDLE).
- IDLE: start=1 -> APPLY. At the same edge: idx <= 0; gate_x/gate_y <= 0/0; err_count <= 0; fail_vec <= 0; pass <= 0.
- APPLY (1 cycle): cnt <= 0 -> WAIT. gate_x = idx[1] and gate_y = idx[0], loaded at the edge entering APPLY. They are held stable through WAIT and SAMPLE.
- WAIT (SETTLE cycles): cnt increments each cycle. When cnt==SETTLE-1 -> SAMPLE.
- SAMPLE (1 cycle): gate_z is compared with EXPECT[idx] at the edge leaving SAMPLE. On mismatch: err_count += 1 and fail_vec[idx] <= 1.
  - idx==3 -> FINISH.
  - Otherwise idx <= idx+1, gate_x/gate_y <= new idx bits, -> APPLY.
- FINISH (1 cycle): pass <= (err_count==0); -> IDLE. err_count already includes vector 3.
- Latency: each vector takes SETTLE+2 cycles. done is high in the cycle following the 4*(SETTLE+2)th rising edge after the edge that sampled start. With SETTLE=2, that is 16 edges.
- start while busy (APPLY..FINISH) is ignored and not queued. A start held high continuously re-launches from IDLE one cycle after FINISH.
- err_count cannot exceed 4, so no saturation logic is needed. It is held after FINISH until the next accepted start.
- pass reads 0 during a sweep. It is valid from the cycle after done.
- rst wins over start if both are high at the same edge.

Test Plan:
1. Correct AND gate attached, SETTLE=2, start pulse -> x/y sequence 00,01,10,11, each held 4 cycles; done 16 edges after start; pass=1, err_count=0, fail_vec=0000.
2. gate_z tied 0 -> done at the same time; pass=0, err_count=1, fail_vec=1000.
3. OR gate attached with EXPECT=4'b1000 -> pass=0, err_count=2, fail_vec=0110; x/y timing identical to test 1.
4. rst asserted 7 cycles into a sweep -> next cycle gate_x=gate_y=busy=done=0, err_count=0, fail_vec=0; no done pulse; a new start then completes normally with pass=1.
5. start re-pulsed at cycles 3 and 10 of a sweep -> ignored; exactly one done; x/y sequence unchanged.
6. Back-to-back runs: run 2 (stuck-0, fails) follows run 1 (correct AND, passes) -> at run 2's start, err_count/fail_vec/pass clear to 0; final pass=0, fail_vec=1000. Also SETTLE=1 -> done 12 edges after start.
